// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter: arbiter state
// encoding, the hard-wired zero register and the datapath widths used by
// MEM/WB and the register file.
package wb_port_arbiter_pkg;

  localparam int WB_ADDR_W = 5;
  localparam int WB_DATA_W = 32;

  // Register r0 reads as zero, so writes aimed at it never use the port.
  localparam int REG_ZERO = 0;

  // Arbiter states: IDLE (no starved request), WAIT (divider lost at least
  // one cycle), FORCE (divider owns the port, pipeline held for one cycle).
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_FORCE = 2'd2;

endpackage

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter. The in-order pipeline writeback normally
// owns the port; the divider's out-of-band result slips in on free cycles.
// After STARVE_LIMIT consecutive lost cycles the divider is forced through
// by stalling MEM/WB for one cycle.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = WB_ADDR_W,
  parameter int DATA_W       = WB_DATA_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              pipe_wr_ctrl_i,
  input  logic [ADDR_W-1:0] pipe_wr_addr_i,
  input  logic [DATA_W-1:0] pipe_wr_data_i,
  input  logic              mc_req_i,
  input  logic [ADDR_W-1:0] mc_addr_i,
  input  logic [DATA_W-1:0] mc_data_i,
  output logic              mc_ack_o,
  output logic              stall_ctrl_o,
  output logic              rf_wr_ctrl_o,
  output logic [ADDR_W-1:0] rf_wr_addr_o,
  output logic [DATA_W-1:0] rf_wr_data_o
);

  // The counter only has to reach STARVE_LIMIT; reaching it moves to FORCE,
  // which clears it, so it can never wrap.
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STARVE_LIMIT);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic              wr_en_d, ack_d;
  logic [ADDR_W-1:0] wr_addr_d;
  logic [DATA_W-1:0] wr_data_d;
  logic              pw, mv, mc_to_r0, same_addr;

  // The pipeline cannot write while it is being held, and the divider's
  // request is stale in the cycle its ack is already visible.
  assign pw        = pipe_wr_ctrl_i && (pipe_wr_addr_i != ADDR_W'(REG_ZERO))
                     && (state_q != ST_FORCE);
  assign mv        = mc_req_i && !mc_ack_o;
  assign mc_to_r0  = (mc_addr_i == ADDR_W'(REG_ZERO));
  assign same_addr = (mc_addr_i == pipe_wr_addr_i);
  assign cnt_inc   = cnt_q + CNT_W'(1);

  // Moore stall: the pipeline is held exactly while the divider is forced.
  assign stall_ctrl_o = (state_q == ST_FORCE);

  // Per-cycle arbitration in priority order; idle cycles keep the last
  // address/data on the port so only the enable toggles.
  always_comb begin
    state_d   = ST_IDLE;
    cnt_d     = '0;
    wr_en_d   = 1'b0;
    ack_d     = 1'b0;
    wr_addr_d = rf_wr_addr_o;
    wr_data_d = rf_wr_data_o;
    if (state_q == ST_FORCE) begin
      if (mv) begin
        wr_en_d   = 1'b1;
        wr_addr_d = mc_addr_i;
        wr_data_d = mc_data_i;
        ack_d     = 1'b1;
      end
    end else if (mv && mc_to_r0) begin
      ack_d = 1'b1;
      if (pw) begin
        wr_en_d   = 1'b1;
        wr_addr_d = pipe_wr_addr_i;
        wr_data_d = pipe_wr_data_i;
      end
    end else if (mv && pw && same_addr) begin
      // The pipeline result is younger, so the divider value is dead.
      wr_en_d   = 1'b1;
      wr_addr_d = pipe_wr_addr_i;
      wr_data_d = pipe_wr_data_i;
      ack_d     = 1'b1;
    end else if (mv && !pw) begin
      wr_en_d   = 1'b1;
      wr_addr_d = mc_addr_i;
      wr_data_d = mc_data_i;
      ack_d     = 1'b1;
    end else if (mv) begin
      wr_en_d   = 1'b1;
      wr_addr_d = pipe_wr_addr_i;
      wr_data_d = pipe_wr_data_i;
      cnt_d     = cnt_inc;
      state_d   = (cnt_inc == CNT_LIMIT) ? ST_FORCE : ST_WAIT;
    end else if (pw) begin
      wr_en_d   = 1'b1;
      wr_addr_d = pipe_wr_addr_i;
      wr_data_d = pipe_wr_data_i;
    end
  end

  // Arbiter state and starvation counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Registered write port and ack: the decision of one cycle shows in the next.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rf_wr_ctrl_o <= 1'b0;
      rf_wr_addr_o <= '0;
      rf_wr_data_o <= '0;
      mc_ack_o     <= 1'b0;
    end else begin
      rf_wr_ctrl_o <= wr_en_d;
      rf_wr_addr_o <= wr_addr_d;
      rf_wr_data_o <= wr_data_d;
      mc_ack_o     <= ack_d;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios with literal expectations plus
// a randomized run, all checked every cycle against a behavioural model of
// the write-port arbitration rules.
module tb_wb_port_arbiter;

  localparam int ADDR_W       = 5;
  localparam int DATA_W       = 32;
  localparam int STARVE_LIMIT = 4;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              pipe_wr_ctrl_i;
  logic [ADDR_W-1:0] pipe_wr_addr_i;
  logic [DATA_W-1:0] pipe_wr_data_i;
  logic              mc_req_i;
  logic [ADDR_W-1:0] mc_addr_i;
  logic [DATA_W-1:0] mc_data_i;
  logic              mc_ack_o;
  logic              stall_ctrl_o;
  logic              rf_wr_ctrl_o;
  logic [ADDR_W-1:0] rf_wr_addr_o;
  logic [DATA_W-1:0] rf_wr_data_o;

  // Model of what the outputs must be after the next edge.
  logic              exp_wr_en;
  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_data;
  logic              exp_ack;
  logic              exp_stall;
  int                lost_cycles;

  int pass_count  = 0;
  int check_count = 0;

  wb_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .pipe_wr_ctrl_i(pipe_wr_ctrl_i), .pipe_wr_addr_i(pipe_wr_addr_i),
    .pipe_wr_data_i(pipe_wr_data_i),
    .mc_req_i(mc_req_i), .mc_addr_i(mc_addr_i), .mc_data_i(mc_data_i),
    .mc_ack_o(mc_ack_o), .stall_ctrl_o(stall_ctrl_o),
    .rf_wr_ctrl_o(rf_wr_ctrl_o), .rf_wr_addr_o(rf_wr_addr_o),
    .rf_wr_data_o(rf_wr_data_o)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic p_en, input int p_addr, input int p_data,
                               input logic m_req, input int m_addr, input int m_data);
    pipe_wr_ctrl_i = p_en;
    pipe_wr_addr_i = ADDR_W'(p_addr);
    pipe_wr_data_i = DATA_W'(p_data);
    mc_req_i       = m_req;
    mc_addr_i      = ADDR_W'(m_addr);
    mc_data_i      = DATA_W'(m_data);
  endtask

  task automatic resetModel();
    exp_wr_en   = 1'b0;
    exp_addr    = '0;
    exp_data    = '0;
    exp_ack     = 1'b0;
    exp_stall   = 1'b0;
    lost_cycles = 0;
  endtask

  // Decide who owns the port at the coming edge, from the arbitration rules.
  task automatic updateModel();
    logic mc_live, pipe_live, take_pipe, take_mc, ack_mc, force_next;
    mc_live    = mc_req_i && !exp_ack;
    pipe_live  = pipe_wr_ctrl_i && (pipe_wr_addr_i != 0) && !exp_stall;
    take_pipe  = 1'b0;
    take_mc    = 1'b0;
    ack_mc     = 1'b0;
    force_next = 1'b0;
    if (exp_stall) begin
      take_mc = mc_live;
      ack_mc  = mc_live;
      lost_cycles = 0;
    end else if (mc_live && mc_addr_i == 0) begin
      ack_mc = 1'b1;
      take_pipe = pipe_live;
      lost_cycles = 0;
    end else if (mc_live && pipe_live && mc_addr_i == pipe_wr_addr_i) begin
      take_pipe = 1'b1;
      ack_mc = 1'b1;
      lost_cycles = 0;
    end else if (mc_live && !pipe_live) begin
      take_mc = 1'b1;
      ack_mc = 1'b1;
      lost_cycles = 0;
    end else if (mc_live) begin
      take_pipe = 1'b1;
      lost_cycles++;
      if (lost_cycles == STARVE_LIMIT) begin
        force_next  = 1'b1;
        lost_cycles = 0;
      end
    end else begin
      take_pipe = pipe_live;
      lost_cycles = 0;
    end
    exp_wr_en = take_pipe || take_mc;
    if (take_pipe) begin
      exp_addr = pipe_wr_addr_i;
      exp_data = pipe_wr_data_i;
    end else if (take_mc) begin
      exp_addr = mc_addr_i;
      exp_data = mc_data_i;
    end
    exp_ack   = ack_mc;
    exp_stall = force_next;
  endtask

  task automatic checkModel();
    checkOutput("rf_wr_ctrl", 64'(rf_wr_ctrl_o), 64'(exp_wr_en));
    checkOutput("rf_wr_addr", 64'(rf_wr_addr_o), 64'(exp_addr));
    checkOutput("rf_wr_data", 64'(rf_wr_data_o), 64'(exp_data));
    checkOutput("mc_ack",     64'(mc_ack_o),     64'(exp_ack));
    checkOutput("stall",      64'(stall_ctrl_o), 64'(exp_stall));
  endtask

  // One clock: predict, let the edge happen, then compare just after it.
  task automatic tick();
    updateModel();
    @(posedge clk_i);
    #1;
    checkModel();
  endtask

  initial begin
    logic new_req;
    rst_i = 1'b1;
    applyStimulus(1'b0, 0, 0, 1'b0, 0, 0);
    resetModel();
    #3;
    checkOutput("por_wr_ctrl", 64'(rf_wr_ctrl_o), 64'd0);
    checkOutput("por_stall", 64'(stall_ctrl_o), 64'd0);
    checkOutput("por_ack", 64'(mc_ack_o), 64'd0);
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // Pipeline-only write.
    applyStimulus(1'b1, 3, 'h11, 1'b0, 0, 0);
    tick();
    checkOutput("pipe_wr_ctrl", 64'(rf_wr_ctrl_o), 64'd1);
    checkOutput("pipe_wr_addr", 64'(rf_wr_addr_o), 64'd3);
    checkOutput("pipe_wr_data", 64'(rf_wr_data_o), 64'h11);
    checkOutput("pipe_stall", 64'(stall_ctrl_o), 64'd0);
    checkOutput("pipe_ack", 64'(mc_ack_o), 64'd0);

    // Divider uses a free slot.
    applyStimulus(1'b0, 0, 0, 1'b1, 7, 'hDEAD);
    tick();
    checkOutput("mc_wr_addr", 64'(rf_wr_addr_o), 64'd7);
    checkOutput("mc_wr_data", 64'(rf_wr_data_o), 64'hDEAD);
    checkOutput("mc_ack_pulse", 64'(mc_ack_o), 64'd1);
    applyStimulus(1'b0, 0, 0, 1'b0, 0, 0);
    tick();
    checkOutput("mc_ack_drop", 64'(mc_ack_o), 64'd0);
    checkOutput("mc_idle_wr", 64'(rf_wr_ctrl_o), 64'd0);
    checkOutput("mc_hold_addr", 64'(rf_wr_addr_o), 64'd7);

    // Starvation: pipeline wins four cycles, then the divider is forced.
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, i, 'h100 + i, 1'b1, 9, 'h99);
      tick();
      checkOutput("starve_pipe_addr", 64'(rf_wr_addr_o), 64'(i));
      checkOutput("starve_stall", 64'(stall_ctrl_o), 64'(i == 4));
    end
    applyStimulus(1'b1, 5, 'h105, 1'b1, 9, 'h99);
    tick();
    checkOutput("force_wr_addr", 64'(rf_wr_addr_o), 64'd9);
    checkOutput("force_wr_data", 64'(rf_wr_data_o), 64'h99);
    checkOutput("force_ack", 64'(mc_ack_o), 64'd1);
    checkOutput("force_unstall", 64'(stall_ctrl_o), 64'd0);
    applyStimulus(1'b1, 5, 'h105, 1'b0, 0, 0);
    tick();
    checkOutput("after_force_addr", 64'(rf_wr_addr_o), 64'd5);
    checkOutput("after_force_data", 64'(rf_wr_data_o), 64'h105);
    applyStimulus(1'b0, 0, 0, 1'b0, 0, 0);
    tick();

    // Same destination: the younger pipeline value wins, divider dropped.
    applyStimulus(1'b1, 4, 'h1, 1'b1, 4, 'h2);
    tick();
    checkOutput("same_addr", 64'(rf_wr_addr_o), 64'd4);
    checkOutput("same_data", 64'(rf_wr_data_o), 64'h1);
    checkOutput("same_ack", 64'(mc_ack_o), 64'd1);
    applyStimulus(1'b0, 0, 0, 1'b0, 0, 0);
    tick();
    checkOutput("same_no_mc_wr", 64'(rf_wr_ctrl_o), 64'd0);

    // r0 targets: divider acked without a write, pipeline ignored.
    applyStimulus(1'b0, 0, 0, 1'b1, 0, 'h5);
    tick();
    checkOutput("r0_mc_ack", 64'(mc_ack_o), 64'd1);
    checkOutput("r0_mc_wr", 64'(rf_wr_ctrl_o), 64'd0);
    applyStimulus(1'b1, 0, 'h77, 1'b0, 0, 0);
    tick();
    checkOutput("r0_pipe_wr", 64'(rf_wr_ctrl_o), 64'd0);

    // Asynchronous reset in the middle of WAIT, then starvation restarts at zero.
    applyStimulus(1'b1, 1, 'h201, 1'b1, 9, 'h300);
    tick();
    applyStimulus(1'b1, 2, 'h202, 1'b1, 9, 'h300);
    tick();
    rst_i = 1'b1;
    #1;
    resetModel();
    checkOutput("rst_wr_ctrl", 64'(rf_wr_ctrl_o), 64'd0);
    checkOutput("rst_wr_addr", 64'(rf_wr_addr_o), 64'd0);
    checkOutput("rst_ack", 64'(mc_ack_o), 64'd0);
    checkOutput("rst_stall", 64'(stall_ctrl_o), 64'd0);
    #2;
    rst_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, i + 10, 'h400 + i, 1'b1, 9, 'h300);
      tick();
      checkOutput("rst_starve_stall", 64'(stall_ctrl_o), 64'(i == 4));
      checkOutput("rst_no_ack", 64'(mc_ack_o), 64'd0);
    end
    tick();
    checkOutput("rst_force_addr", 64'(rf_wr_addr_o), 64'd9);
    applyStimulus(1'b0, 0, 0, 1'b0, 0, 0);
    tick();

    // Randomized traffic; the drivers follow the handshake as real units would.
    for (int n = 0; n < 600; n++) begin
      if (!stall_ctrl_o) begin
        pipe_wr_ctrl_i = ($urandom_range(0, 99) < 70);
        pipe_wr_addr_i = ADDR_W'($urandom_range(0, 7));
        pipe_wr_data_i = DATA_W'($urandom);
      end
      if (mc_ack_o) begin
        new_req = ($urandom_range(0, 1) == 1);
        mc_req_i = new_req;
        mc_addr_i = ADDR_W'($urandom_range(0, 7));
        mc_data_i = DATA_W'($urandom);
      end else if (!mc_req_i && $urandom_range(0, 99) < 30) begin
        mc_req_i = 1'b1;
        mc_addr_i = ADDR_W'($urandom_range(0, 7));
        mc_data_i = DATA_W'($urandom);
      end
      tick();
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
